// File: rtl/tiny_dnn_sequencer_if.sv
// Stream and AXI-Lite master bundle for tiny_dnn_sequencer.
// The master modport is the sequencer side; slave is the accelerator/stream environment.
interface tiny_dnn_sequencer_if;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;

    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        output M_AXI_AWADDR, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        input  M_AXI_AWADDR, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/tiny_dnn_sequencer.sv
// Streams weights into the tiny_dnn accelerator over AXI-Lite, runs it, streams results out.
// Optional watchdog on outstanding AW/AR: define TINY_DNN_SEQ_TIMEOUT_EN.
module tiny_dnn_sequencer #(
    parameter int          F_NUM = 16,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  start,
    input  logic                  cfg_init,
    input  logic [12:0]           cfg_load_addr,
    input  logic [13:0]           cfg_word_cnt,
    input  logic [8:0]            cfg_exec_off,
    tiny_dnn_sequencer_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int FW = (F_NUM > 1) ? $clog2(F_NUM) : 1;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_LOAD, S_EXEC, S_READ, S_DONE} state_t;
    state_t state_q, state_d;

    logic [8:0]    exec_off_q;
    logic [12:0]   n_q;
    logic [13:0]   remain_q;
    logic          short_q;
    logic [FW-1:0] f_q, f_d;
    logic          aw_valid_q, w_valid_q, b_ready_q, wr_busy_q;
    logic          ar_valid_q, rd_busy_q;
    logic [31:0]   awaddr_q, wr_addr_d, araddr_q;
    logic [15:0]   wdata_q, wr_data_d;
    logic [31:0]   m_data_q;
    logic          m_valid_q, m_last_q, err_q;
    logic          wr_issue, ar_issue;
    logic          s_ready, r_ready, s_hs, b_hs, r_hs, m_hs, wd_hit;

    assign s_ready = (state_q == S_LOAD) && !wr_busy_q && (remain_q != 14'd0) && !short_q;
    assign r_ready = (state_q == S_READ) && rd_busy_q && !m_valid_q;
    assign s_hs    = s_ready && bus.s_axis_tvalid;
    assign b_hs    = b_ready_q && bus.M_AXI_BVALID;
    assign r_hs    = r_ready && bus.M_AXI_RVALID;
    assign m_hs    = m_valid_q && bus.m_axis_tready;

`ifdef TINY_DNN_SEQ_TIMEOUT_EN
    logic [15:0] wd_q;
    assign wd_hit = (wd_q == 16'hFFFF);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)              wd_q <= '0;
        else if (wr_issue || ar_issue || wd_hit) wd_q <= '0;
        else if (wr_busy_q || rd_busy_q) wd_q <= wd_q + 16'd1;
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        wr_issue  = 1'b0;
        wr_addr_d = awaddr_q;
        wr_data_d = wdata_q;
        ar_issue  = 1'b0;
        f_d       = f_q;
        case (state_q)
            S_IDLE: if (start) begin
                if (cfg_init) begin
                    state_d   = S_INIT;
                    wr_issue  = 1'b1;
                    wr_addr_d = BASE | 32'h0000_FFFC;
                    wr_data_d = 16'h0;
                end else if (cfg_word_cnt != 14'd0) begin
                    state_d = S_LOAD;
                end else begin
                    state_d   = S_EXEC;
                    wr_issue  = 1'b1;
                    wr_addr_d = BASE | 32'h8000 | {21'b0, cfg_exec_off, 2'b00};
                    wr_data_d = 16'h0;
                end
            end
            S_INIT: if (b_hs) begin
                if (remain_q != 14'd0) begin
                    state_d = S_LOAD;
                end else begin
                    state_d   = S_EXEC;
                    wr_issue  = 1'b1;
                    wr_addr_d = BASE | 32'h8000 | {21'b0, exec_off_q, 2'b00};
                    wr_data_d = 16'h0;
                end
            end
            S_LOAD: begin
                if (s_hs) begin
                    wr_issue  = 1'b1;
                    wr_addr_d = BASE | {17'b0, n_q, 2'b00};
                    wr_data_d = bus.s_axis_tdata;
                end
                // short stream: the written beat finishes, then jump straight to readback
                if (b_hs) begin
                    if (short_q) begin
                        state_d  = S_READ;
                        ar_issue = 1'b1;
                        f_d      = '0;
                    end else if (remain_q == 14'd0) begin
                        state_d   = S_EXEC;
                        wr_issue  = 1'b1;
                        wr_addr_d = BASE | 32'h8000 | {21'b0, exec_off_q, 2'b00};
                        wr_data_d = 16'h0;
                    end
                end
            end
            S_EXEC: if (b_hs) begin
                state_d  = S_READ;
                ar_issue = 1'b1;
                f_d      = '0;
            end
            S_READ: if (m_hs) begin
                if (m_last_q) begin
                    state_d = S_DONE;
                end else begin
                    ar_issue = 1'b1;
                    f_d      = f_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (wd_hit) begin
            state_d  = S_DONE;
            wr_issue = 1'b0;
            ar_issue = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            exec_off_q <= '0;
            n_q        <= '0;
            remain_q   <= '0;
            short_q    <= 1'b0;
            f_q        <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            wr_busy_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            rd_busy_q  <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            araddr_q   <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                exec_off_q <= cfg_exec_off;
                n_q        <= cfg_load_addr;
                remain_q   <= cfg_word_cnt;
                short_q    <= 1'b0;
                err_q      <= 1'b0;
            end
            if (s_hs) begin
                n_q      <= n_q + 13'd1;
                remain_q <= remain_q - 14'd1;
                if (bus.s_axis_tlast && remain_q != 14'd1) begin
                    short_q <= 1'b1;
                    err_q   <= 1'b1;
                end
            end

            if (aw_valid_q && bus.M_AXI_AWREADY) aw_valid_q <= 1'b0;
            if (w_valid_q && bus.M_AXI_WREADY)   w_valid_q  <= 1'b0;
            if (b_hs) begin
                b_ready_q <= 1'b0;
                wr_busy_q <= 1'b0;
                if (bus.M_AXI_BRESP != 2'b00) err_q <= 1'b1;
            end
            // a new write may be issued on the B handshake edge, so it overrides the clears above
            if (wr_issue) begin
                aw_valid_q <= 1'b1;
                w_valid_q  <= 1'b1;
                b_ready_q  <= 1'b1;
                wr_busy_q  <= 1'b1;
                awaddr_q   <= wr_addr_d;
                wdata_q    <= wr_data_d;
            end

            if (ar_valid_q && bus.M_AXI_ARREADY) ar_valid_q <= 1'b0;
            if (r_hs) begin
                rd_busy_q <= 1'b0;
                m_data_q  <= bus.M_AXI_RDATA;
                m_valid_q <= 1'b1;
                m_last_q  <= (f_q == FW'(F_NUM - 1));
                if (bus.M_AXI_RRESP != 2'b00) err_q <= 1'b1;
            end
            if (m_hs) m_valid_q <= 1'b0;
            if (ar_issue) begin
                ar_valid_q <= 1'b1;
                rd_busy_q  <= 1'b1;
                araddr_q   <= BASE | 32'h8000 | (32'(f_d) << 2);
                f_q        <= f_d;
            end

            if (wd_hit) begin
                aw_valid_q <= 1'b0;
                w_valid_q  <= 1'b0;
                b_ready_q  <= 1'b0;
                wr_busy_q  <= 1'b0;
                ar_valid_q <= 1'b0;
                rd_busy_q  <= 1'b0;
                err_q      <= 1'b1;
            end
        end
    end

    assign bus.s_axis_tready = s_ready;
    assign bus.m_axis_tdata  = m_data_q;
    assign bus.m_axis_tvalid = m_valid_q;
    assign bus.m_axis_tlast  = m_last_q;
    assign bus.M_AXI_AWADDR  = awaddr_q;
    assign bus.M_AXI_AWVALID = aw_valid_q;
    assign bus.M_AXI_WDATA   = {wdata_q, 16'h0000};
    assign bus.M_AXI_WSTRB   = 4'b1100;
    assign bus.M_AXI_WVALID  = w_valid_q;
    assign bus.M_AXI_BREADY  = b_ready_q;
    assign bus.M_AXI_ARADDR  = araddr_q;
    assign bus.M_AXI_ARVALID = ar_valid_q;
    assign bus.M_AXI_RREADY  = r_ready;

    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done = (state_q == S_DONE);
    assign err  = err_q;
endmodule

// File: tb/tb_tiny_dnn_sequencer.sv
// Directed bench for tiny_dnn_sequencer: behavioural AXI-Lite slave and stream sink
// respond on the falling edge; the initial block drives jobs and checks the logs.
module tb_tiny_dnn_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cfg_init = 1'b0;
    logic [12:0] cfg_load_addr = '0;
    logic [13:0] cfg_word_cnt = '0;
    logic [8:0]  cfg_exec_off = '0;
    logic        busy, done, err;

    always #5 clk = ~clk;

    tiny_dnn_sequencer_if bus();

    tiny_dnn_sequencer #(.F_NUM(16), .BASE(32'h0)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .cfg_init(cfg_init),
        .cfg_load_addr(cfg_load_addr), .cfg_word_cnt(cfg_word_cnt), .cfg_exec_off(cfg_exec_off),
        .bus(bus), .busy(busy), .done(done), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
    int stall_at = -1, stall_len = 0, stall_left = 0;
    logic [1:0] bresp_knob = 2'b00;
    logic [31:0] aw_q[$], w_q[$], ar_q[$], out_q[$], exp_aw[$], exp_w[$];
    bit last_q[$];
    int strb_bad = 0, bready_bad = 0, rready_bad = 0, ar_ahead_bad = 0, done_cnt = 0, s_cnt = 0;

    bit aw_fire, w_fire, b_fire, ar_fire, r_fire, aw_got, w_got, r_pend, bready_prev;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [31:0] r_addr;

    // slave + sink: decide readies for the coming rising edge, log handshakes that will occur on it
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = 0;
            bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0; bus.M_AXI_RDATA = 0; bus.M_AXI_RRESP = 0;
            bus.m_axis_tready = 1;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            aw_got = 0; w_got = 0; r_pend = 0; bready_prev = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        end else begin
            if (bready_prev && !bus.M_AXI_BREADY && !b_fire) bready_bad++;
            bready_prev = bus.M_AXI_BREADY;
            if (aw_fire) begin bus.M_AXI_AWREADY = 0; aw_got = 1; end
            if (w_fire)  begin bus.M_AXI_WREADY = 0;  w_got = 1; end
            if (b_fire)  bus.M_AXI_BVALID = 0;
            if (ar_fire) begin bus.M_AXI_ARREADY = 0; r_pend = 1; r_wait = 0; end
            if (r_fire)  bus.M_AXI_RVALID = 0;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;

            if (aw_got && w_got && !bus.M_AXI_BVALID) begin
                if (b_wait >= b_delay) begin
                    bus.M_AXI_BVALID = 1; bus.M_AXI_BRESP = bresp_knob;
                    aw_got = 0; w_got = 0; b_wait = 0;
                end else b_wait++;
            end
            if (bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY) begin
                if (aw_wait >= aw_delay) begin bus.M_AXI_AWREADY = 1; aw_wait = 0; end else aw_wait++;
            end
            if (bus.M_AXI_WVALID && !bus.M_AXI_WREADY) begin
                if (w_wait >= w_delay) begin bus.M_AXI_WREADY = 1; w_wait = 0; end else w_wait++;
            end
            if (bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY) begin
                if (ar_wait >= 0) begin bus.M_AXI_ARREADY = 1; ar_wait = 0; end
            end
            if (r_pend && !bus.M_AXI_RVALID) begin
                if (r_wait >= r_delay) begin
                    bus.M_AXI_RVALID = 1; bus.M_AXI_RDATA = 32'hA500_0000 | r_addr; bus.M_AXI_RRESP = 0;
                    r_pend = 0;
                end else r_wait++;
            end
            if (out_q.size() == stall_at) begin stall_left = stall_len; stall_at = -1; end
            if (stall_left > 0) begin bus.m_axis_tready = 0; stall_left--; end
            else bus.m_axis_tready = 1;

            if (bus.m_axis_tvalid && bus.M_AXI_RREADY) rready_bad++;
            if (ar_q.size() > out_q.size() + 1) ar_ahead_bad++;
            if (done) done_cnt++;

            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin aw_fire = 1; aw_q.push_back(bus.M_AXI_AWADDR); end
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
                w_fire = 1; w_q.push_back(bus.M_AXI_WDATA);
                if (bus.M_AXI_WSTRB !== 4'b1100) strb_bad++;
            end
            if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) b_fire = 1;
            if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
                ar_fire = 1; ar_q.push_back(bus.M_AXI_ARADDR); r_addr = bus.M_AXI_ARADDR;
            end
            if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) r_fire = 1;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                out_q.push_back(bus.m_axis_tdata); last_q.push_back(bus.m_axis_tlast);
            end
            if (bus.s_axis_tvalid && bus.s_axis_tready) s_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic start_job(input bit i, input logic [12:0] a, input logic [13:0] c, input logic [8:0] o);
        aw_q.delete(); w_q.delete(); ar_q.delete(); out_q.delete(); last_q.delete();
        done_cnt = 0; s_cnt = 0;
        cfg_init = i; cfg_load_addr = a; cfg_word_cnt = c; cfg_exec_off = o; start = 1;
        step();
        start = 0;
        // scramble cfg so later use of unlatched inputs shows up
        cfg_init = ~i; cfg_load_addr = ~a; cfg_word_cnt = 14'd3; cfg_exec_off = ~o;
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic push_word(input logic [15:0] d, input bit last);
        int n = 0;
        bus.s_axis_tdata = d; bus.s_axis_tvalid = 1; bus.s_axis_tlast = last;
        while (!bus.s_axis_tready && n < 1000) begin step(); n++; end
        chk("tready_wait", n < 1000, 1'b1);
        step();
        bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 3000) begin step(); n++; end
        chk("done_wait", n < 3000, 1'b1);
        step();
        chk("done_pulses", done_cnt, 1);
        chk("busy_idle", busy, 1'b0);
    endtask

    task automatic check_writes();
        chk("aw_count", aw_q.size(), exp_aw.size());
        chk("w_count", w_q.size(), exp_w.size());
        for (int i = 0; i < exp_aw.size(); i++)
            if (i < aw_q.size()) chk($sformatf("awaddr%0d", i), aw_q[i], exp_aw[i]);
        for (int i = 0; i < exp_w.size(); i++)
            if (i < w_q.size()) chk($sformatf("wdata%0d", i), w_q[i], exp_w[i]);
        chk("wstrb", strb_bad, 0);
    endtask

    task automatic check_reads();
        chk("ar_count", ar_q.size(), 16);
        chk("beat_count", out_q.size(), 16);
        for (int f = 0; f < 16; f++) begin
            if (f < ar_q.size()) chk($sformatf("araddr%0d", f), ar_q[f], 32'h8000 + 32'(4 * f));
            if (f < out_q.size()) begin
                chk($sformatf("beat%0d", f), out_q[f], 32'hA500_8000 + 32'(4 * f));
                chk($sformatf("tlast%0d", f), last_q[f], f == 15);
            end
        end
        chk("rready_full", rready_bad, 0);
        chk("ar_ahead", ar_ahead_bad, 0);
    endtask

    initial begin
        bus.s_axis_tdata = 0; bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0;
        repeat (3) step();
        chk("reset_outs", {busy, done, err, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                           bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.s_axis_tready, bus.m_axis_tvalid}, '0);
        rst_n = 1;
        step();

        // init + 4-word load, slave always ready
        start_job(1, 13'h200, 14'd4, 9'd0);
        push_word(16'h1111, 0); push_word(16'h2222, 0); push_word(16'h3333, 0); push_word(16'h4444, 1);
        wait_done();
        exp_aw = '{32'hFFFC, 32'h800, 32'h804, 32'h808, 32'h80C, 32'h8000};
        exp_w  = '{32'h0, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000, 32'h0};
        check_writes();
        check_reads();
        chk("err_clean", err, 1'b0);

        // AWREADY late, B delayed; a start mid-job must be ignored
        aw_delay = 3; b_delay = 2;
        start_job(0, 13'h0, 14'd2, 9'd5);
        push_word(16'hAAAA, 0);
        cfg_init = 1; cfg_word_cnt = 14'd7; start = 1; step(); start = 0;
        push_word(16'h5555, 1);
        wait_done();
        exp_aw = '{32'h0, 32'h4, 32'h8014};
        exp_w  = '{32'hAAAA_0000, 32'h5555_0000, 32'h0};
        check_writes();
        check_reads();
        chk("bready_hold", bready_bad, 0);
        aw_delay = 0; b_delay = 0;

        // early tlast on beat 2 of 5
        start_job(0, 13'h10, 14'd5, 9'd0);
        push_word(16'h0101, 0); push_word(16'h0202, 1);
        wait_done();
        exp_aw = '{32'h40, 32'h44};
        exp_w  = '{32'h0101_0000, 32'h0202_0000};
        check_writes();
        check_reads();
        chk("err_short", err, 1'b1);

        // address wrap, output stall mid-readback, slow R
        stall_at = 5; stall_len = 10; r_delay = 2;
        start_job(0, 13'h1FFF, 14'd2, 9'h1FF);
        chk("err_cleared", err, 1'b0);
        push_word(16'h1234, 0); push_word(16'h5678, 1);
        wait_done();
        exp_aw = '{32'h7FFC, 32'h0, 32'h87FC};
        exp_w  = '{32'h1234_0000, 32'h5678_0000, 32'h0};
        check_writes();
        check_reads();
        chk("err_wrap", err, 1'b0);
        r_delay = 0;

        // BRESP error: sticky err, sequence still completes
        bresp_knob = 2'b10;
        start_job(0, 13'h3, 14'd1, 9'd0);
        push_word(16'hBEEF, 1);
        wait_done();
        exp_aw = '{32'hC, 32'h8000};
        exp_w  = '{32'hBEEF_0000, 32'h0};
        check_writes();
        check_reads();
        chk("err_bresp", err, 1'b1);
        bresp_knob = 2'b00;

        // zero-length load with a beat on offer: nothing consumed
        bus.s_axis_tdata = 16'hDEAD; bus.s_axis_tvalid = 1;
        start_job(0, 13'h0, 14'd0, 9'd2);
        wait_done();
        bus.s_axis_tvalid = 0;
        chk("no_beats", s_cnt, 0);
        exp_aw = '{32'h8008};
        exp_w  = '{32'h0};
        check_writes();
        check_reads();

        // reset mid-LOAD after 3 words
        start_job(0, 13'h0, 14'd8, 9'd0);
        push_word(16'h0010, 0); push_word(16'h0020, 0); push_word(16'h0030, 0);
        chk("awvalid_inflight", bus.M_AXI_AWVALID, 1'b1);
        #1 rst_n = 0;
        #1 chk("reset_mid", {busy, done, err, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                             bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.s_axis_tready, bus.m_axis_tvalid}, '0);
        step(); step();
        rst_n = 1;
        step();
        start_job(0, 13'h100, 14'd1, 9'd0);
        push_word(16'h7777, 1);
        wait_done();
        exp_aw = '{32'h400, 32'h8000};
        exp_w  = '{32'h7777_0000, 32'h0};
        check_writes();
        check_reads();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
